// File: rtl/enemy_pkg.sv
// Shared edge codes and detector state encoding for the enemy collision path.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package enemy_pkg;

  // One-hot sprite edge codes, also decoded by the enemy motion FSM
  localparam logic [3:0] TOP    = 4'b0100;
  localparam logic [3:0] RIGHT  = 4'b0010;
  localparam logic [3:0] LEFT   = 4'b1000;
  localparam logic [3:0] BOTTOM = 4'b0001;
  localparam logic [3:0] NONE   = 4'b0000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_REPORTED = 2'd2
  } hit_state_t;

endpackage

// File: rtl/enemy_hit_detector_hit_edge_encoder.sv
// Classifies a sprite-relative pixel offset into an edge zone and flags in-box pixels.
// Latency: combinational.
// Backpressure: none.
module hit_edge_encoder
  import enemy_pkg::*;
#(
  parameter int OBJECT_WIDTH_X = 32,
  parameter int OBJECT_HIGHT_Y = 32,
  parameter int EDGE_DEPTH     = 4
) (
  input  logic signed [11:0] offX,
  input  logic signed [11:0] offY,
  output logic        [3:0]  edgeCode,
  output logic               inBox
);

  localparam logic signed [11:0] WIDTH_S  = 12'(OBJECT_WIDTH_X);
  localparam logic signed [11:0] HEIGHT_S = 12'(OBJECT_HIGHT_Y);
  localparam logic signed [11:0] DEPTH_S  = 12'(EDGE_DEPTH);
  localparam logic signed [11:0] BOT_S    = 12'(OBJECT_HIGHT_Y - EDGE_DEPTH);
  localparam logic signed [11:0] RGT_S    = 12'(OBJECT_WIDTH_X - EDGE_DEPTH);

  // Top/bottom rows win over left/right columns, so corners report TOP or BOTTOM
  always_comb begin
    inBox    = (offX >= 12'sd0) && (offX < WIDTH_S) &&
               (offY >= 12'sd0) && (offY < HEIGHT_S);
    edgeCode = NONE;
    if (offY < DEPTH_S)       edgeCode = TOP;
    else if (offY >= BOT_S)   edgeCode = BOTTOM;
    else if (offX < DEPTH_S)  edgeCode = LEFT;
    else if (offX >= RGT_S)   edgeCode = RIGHT;
  end

endmodule

// File: rtl/enemy_hit_detector.sv
// Detects enemy/obstacle overlap, reports first edge hit per frame (ENEMY_HIT_DIR_FILTER_EN: leading edge only).
// Latency: candidate pixel to collision pulse is 2 cycles; startOfFrame clear is 1 cycle.
// Backpressure: none, follows the free-running pixel scan.
module enemy_hit_detector
  import enemy_pkg::*;
#(
  parameter int OBJECT_WIDTH_X = 32,
  parameter int OBJECT_HIGHT_Y = 32,
  parameter int EDGE_DEPTH     = 4
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               game_on,
  input  logic        [10:0] pixelX,
  input  logic        [10:0] pixelY,
  input  logic signed [10:0] topLeftX,
  input  logic signed [10:0] topLeftY,
  input  logic               enemyDR,
  input  logic               obstacleDR,
  input  logic        [3:0]  direction,
  output logic               collision,
  output logic        [3:0]  HitEdgeCode,
  output logic        [3:0]  edges_seen
);

  logic        [10:0] pix_x_d, pix_y_d;
  logic signed [10:0] tl_x_d, tl_y_d;
  logic               overlap_d;
  logic signed [11:0] off_x, off_y;
  logic        [3:0]  edge_code;
  logic               in_box;
  logic               classified;
  logic               qualify;
  hit_state_t         state;

  // Stage 1: capture the scan; an overlap coinciding with startOfFrame is dropped here
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pix_x_d   <= '0;
      pix_y_d   <= '0;
      tl_x_d    <= '0;
      tl_y_d    <= '0;
      overlap_d <= 1'b0;
    end else begin
      pix_x_d   <= pixelX;
      pix_y_d   <= pixelY;
      tl_x_d    <= topLeftX;
      tl_y_d    <= topLeftY;
      overlap_d <= enemyDR && obstacleDR && !startOfFrame;
    end
  end

  assign off_x = $signed({1'b0, pix_x_d}) - $signed({tl_x_d[10], tl_x_d});
  assign off_y = $signed({1'b0, pix_y_d}) - $signed({tl_y_d[10], tl_y_d});

  hit_edge_encoder #(
    .OBJECT_WIDTH_X (OBJECT_WIDTH_X),
    .OBJECT_HIGHT_Y (OBJECT_HIGHT_Y),
    .EDGE_DEPTH     (EDGE_DEPTH)
  ) u_encoder (
    .offX     (off_x),
    .offY     (off_y),
    .edgeCode (edge_code),
    .inBox    (in_box)
  );

  assign classified = overlap_d && in_box && (edge_code != NONE);

`ifdef ENEMY_HIT_DIR_FILTER_EN
  logic [3:0] dir_d;

  // Direction travels with the pixel so the leading-edge compare sees matching data
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) dir_d <= '0;
    else         dir_d <= direction;
  end

  assign qualify = (edge_code == dir_d);
`else
  logic unused_direction;
  assign unused_direction = ^direction;
  assign qualify          = 1'b1;
`endif

  // Stage 2: frame FSM; game_on and startOfFrame act on the raw inputs for a 1-cycle clear
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= ST_IDLE;
      collision   <= 1'b0;
      HitEdgeCode <= NONE;
      edges_seen  <= NONE;
    end else if (!game_on) begin
      state       <= ST_IDLE;
      collision   <= 1'b0;
      HitEdgeCode <= NONE;
      edges_seen  <= NONE;
    end else begin
      collision <= 1'b0;
      case (state)
        ST_IDLE: begin
          HitEdgeCode <= NONE;
          edges_seen  <= NONE;
          if (startOfFrame) state <= ST_ARMED;
        end
        ST_ARMED, ST_REPORTED: begin
          if (startOfFrame) begin
            HitEdgeCode <= NONE;
            edges_seen  <= NONE;
            state       <= ST_ARMED;
          end else if (classified) begin
            edges_seen <= edges_seen | edge_code;
            if ((state == ST_ARMED) && qualify) begin
              collision   <= 1'b1;
              HitEdgeCode <= edge_code;
              state       <= ST_REPORTED;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
